elbeth_fetch_stage: RTL and testbench

//  Instruction-fetch stage of the ELBETH RV32I pipeline, directly upstream of elbeth_decoder.

---
 rtl/elbeth_fetch_pkg.sv | 26 ++
 rtl/elbeth_fetch_queue.sv | 47 ++++
 rtl/elbeth_fetch_stage.sv | 127 ++++++++++++
 tb/tb_elbeth_fetch_stage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elbeth_fetch_pkg.sv
// Shared definitions for the ELBETH fetch stage: NOP encoding, exception source
// code, fetch FSM state codes and the fetch-queue entry layout.
package elbeth_fetch_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // Fetch-stage exception source; zero means "no exception" on if_except_src.
  localparam logic [3:0] ECODE_INST_ADDR_MISALIGNED = 4'h1;

  typedef enum logic [1:0] {
    FETCH_RUN  = 2'b00,
    FETCH_WAIT = 2'b01,
    FETCH_DROP = 2'b10
  } fetch_state_e;

  typedef struct packed {
    logic        xcpt;
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/elbeth_fetch_queue.sv
// Two-entry FIFO of fetched {xcpt, pc, inst} entries with flush; head is
// presented combinationally to the IF/ID boundary.
module elbeth_fetch_queue
  import elbeth_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         empty,
  output logic [1:0]   count
);

  fetch_entry_t slots [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         full;
  logic         push_ok;
  logic         pop_ok;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = slots[rd_ptr];

  // Flush wins over a simultaneous push so a redirect never leaks an old entry.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) slots[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/elbeth_fetch_stage.sv
// ELBETH RV32I instruction fetch: owns the PC, keeps one request outstanding to
// instruction memory, buffers words in a 2-entry queue and handles redirects.
module elbeth_fetch_stage
  import elbeth_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0200,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  input  logic        csr_xcpt,
  input  logic [31:0] csr_xcpt_pc,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        if_xcpt,
  output logic [3:0]  if_except_src
);

  localparam logic [1:0] QCAP = 2'(QDEPTH);

  fetch_state_e state, state_next;
  logic [31:0]  pc;
  logic [31:0]  req_pc;
  logic         halted;
  logic         xcpt_pending;
  logic         redirect;
  logic [31:0]  target;
  logic [1:0]   occ_after;

  fetch_entry_t q_head;
  fetch_entry_t q_push_data;
  logic         q_push;
  logic         q_pop;
  logic         q_empty;
  logic [1:0]   q_count;

  assign redirect  = csr_xcpt | ex_redirect;
  assign target    = csr_xcpt ? csr_xcpt_pc : ex_target;
  assign imem_addr = {pc[31:2], 2'b00};
  assign q_pop     = ~q_empty & ~id_stall;

  elbeth_fetch_queue u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .head      (q_head),
    .empty     (q_empty),
    .count     (q_count)
  );

  // imem handshake: imem_req is a valid, imem_gnt its ready; a request transfers
  // on imem_req & imem_gnt, and once raised it holds imem_addr until granted
  // unless a redirect cancels it. Responses arrive in order on imem_rvalid.
  always_comb begin
    state_next  = state;
    imem_req    = 1'b0;
    q_push      = 1'b0;
    q_push_data = '{xcpt: 1'b0, pc: req_pc, inst: imem_rdata};
    occ_after   = q_count + 2'd1 - {1'b0, q_pop};
    unique case (state)
      FETCH_RUN: begin
        imem_req = ~halted & ~redirect & (q_count < QCAP);
        if (imem_req && imem_gnt) state_next = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (redirect) begin
          state_next = imem_rvalid ? FETCH_RUN : FETCH_DROP;
        end else if (imem_rvalid) begin
          q_push     = 1'b1;
          // The returning word takes the slot it reserved; the next fetch
          // needs a further slot once this cycle's pop is accounted for.
          imem_req   = occ_after < QCAP;
          state_next = (imem_req && imem_gnt) ? FETCH_WAIT : FETCH_RUN;
        end
      end
      FETCH_DROP: begin
        if (imem_rvalid) state_next = FETCH_RUN;
      end
      default: state_next = FETCH_RUN;
    endcase
    if (xcpt_pending) begin
      q_push      = 1'b1;
      q_push_data = '{xcpt: 1'b1, pc: pc, inst: NOP};
    end
    if (rst) imem_req = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FETCH_RUN;
      pc           <= RESET_PC;
      req_pc       <= 32'h0;
      halted       <= 1'b0;
      xcpt_pending <= 1'b0;
    end else begin
      state        <= state_next;
      xcpt_pending <= 1'b0;
      if (redirect) begin
        pc           <= target;
        halted       <= misaligned(target);
        xcpt_pending <= misaligned(target);
      end else if (imem_req && imem_gnt) begin
        req_pc <= pc;
        pc     <= pc + 32'd4;
      end
    end
  end

  assign if_valid      = ~q_empty;
  assign if_inst       = q_empty ? NOP : q_head.inst;
  assign if_pc         = q_empty ? 32'h0 : q_head.pc;
  assign if_xcpt       = ~q_empty & q_head.xcpt;
  assign if_except_src = if_xcpt ? ECODE_INST_ADDR_MISALIGNED : 4'h0;

endmodule

// File: tb/tb_elbeth_fetch_stage.sv
// Bench for elbeth_fetch_stage: random-latency memory model, instruction-stream
// reference model (expected queue) and directed redirect/stall/reset scenarios.
module tb_elbeth_fetch_stage;
  import elbeth_fetch_pkg::*;

  localparam int W = 65;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic        csr_xcpt;
  logic [31:0] csr_xcpt_pc;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_xcpt;
  logic [3:0]  if_except_src;

  elbeth_fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .id_stall      (id_stall),
    .ex_redirect   (ex_redirect),
    .ex_target     (ex_target),
    .csr_xcpt      (csr_xcpt),
    .csr_xcpt_pc   (csr_xcpt_pc),
    .if_valid      (if_valid),
    .if_inst       (if_inst),
    .if_pc         (if_pc),
    .if_xcpt       (if_xcpt),
    .if_except_src (if_except_src)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_accept = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0]  m_pc = 32'h200;
  bit           m_halt = 1'b0;
  logic [31:0]  last_acc_pc = 32'h0;

  // memory model
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  int          cyc = 0;
  int          gnt_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          gnt_block = 1'b0;

  // per-cycle observations and protocol history
  logic        obs_req, obs_gnt, obs_valid, obs_xcpt;
  logic [31:0] obs_addr, obs_pc, obs_inst;
  logic [3:0]  obs_src;
  bit          prev_pending = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  bit          flush_due = 1'b0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
  endfunction

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver: one clock cycle, called at a negedge ----------------
  task automatic step(input bit stall, input bit exr, input logic [31:0] ext,
                      input bit csr, input logic [31:0] csrt, input bit rst_in);
    logic        redir;
    logic [31:0] tgt;
    logic [W-1:0] e;
    rst = rst_in; id_stall = stall;
    ex_redirect = exr; ex_target = ext; csr_xcpt = csr; csr_xcpt_pc = csrt;
    if (mem_addr_q.size() > 0 && cyc >= mem_due_q[0]) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_at(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    if (mem_addr_q.size() == 0) gnt_block = 1'b0;
    #1;
    imem_gnt = imem_req && !gnt_block && (int'($urandom_range(99)) < gnt_pct);
    obs_req = imem_req; obs_gnt = imem_gnt; obs_addr = imem_addr;
    obs_valid = if_valid; obs_pc = if_pc; obs_inst = if_inst;
    obs_xcpt = if_xcpt; obs_src = if_except_src;
    redir = !rst_in && (csr || exr);
    tgt   = csr ? csrt : ext;
    if (!rst_in) begin
      if (imem_req) check_eq("addr_align", W'(imem_addr[1:0]), W'(0));
      if (prev_pending && !redir) begin
        check_eq("req_hold", W'(imem_req), W'(1));
        check_eq("addr_hold", W'(imem_addr), W'(prev_addr));
      end
      if (redir)     check_eq("redir_no_req", W'(imem_req), W'(0));
      if (m_halt)    check_eq("halt_no_req", W'(imem_req), W'(0));
      if (flush_due) check_eq("flush_valid", W'(if_valid), W'(0));
      if (imem_req && imem_gnt) check_eq("one_outstanding", W'(mem_addr_q.size()), W'(0));
      if (if_valid && !stall) begin
        if (exp_q.size() == 0 && !m_halt) begin
          exp_q.push_back({1'b0, m_pc, word_at(m_pc)});
          m_pc = m_pc + 32'd4;
        end
        if (exp_q.size() == 0) begin
          check_eq("spurious_valid", W'(if_valid), W'(0));
        end else begin
          e = exp_q.pop_front();
          check_eq("accept", {if_xcpt, if_pc, if_inst}, e);
          check_eq("except_src", W'(if_except_src),
                   W'(e[64] ? ECODE_INST_ADDR_MISALIGNED : 4'h0));
          n_accept++;
          last_acc_pc = if_pc;
        end
      end
    end
    // model update for the coming edge
    if (imem_req && imem_gnt) begin
      mem_addr_q.push_back(imem_addr);
      mem_due_q.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
    end
    flush_due    = redir;
    prev_pending = !rst_in && imem_req && !imem_gnt;
    prev_addr    = imem_addr;
    if (rst_in) begin
      exp_q.delete();
      m_pc = 32'h200; m_halt = 1'b0; flush_due = 1'b0; prev_pending = 1'b0;
    end else if (redir) begin
      exp_q.delete();
      m_pc   = tgt;
      m_halt = (tgt[1:0] != 2'b00);
      if (m_halt) exp_q.push_back({1'b1, tgt, 32'h0000_0013});
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic step_idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    if (mem_addr_q.size() > 0) gnt_block = 1'b1;
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check_eq("rst_req", W'(imem_req), W'(0));
    check_eq("rst_valid", W'(if_valid), W'(0));
    check_eq("rst_inst", W'(if_inst), W'(32'h0000_0013));
    check_eq("rst_pc", W'(if_pc), W'(0));
    check_eq("rst_xcpt", W'({if_xcpt, if_except_src}), W'(0));
  endtask

  task automatic run_until_grant(input logic [31:0] addr, input bit any, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      step_idle();
      if (obs_req && obs_gnt && (any || obs_addr == addr)) found = 1'b1;
    end
    check_eq("grant_wait", W'(found), W'(1));
  endtask

  task automatic run_until_valid(input string tag, input logic [31:0] exp_pc, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      step_idle();
      if (obs_valid) found = 1'b1;
    end
    check_eq("valid_wait", W'(found), W'(1));
    check_eq(tag, W'(obs_pc), W'(exp_pc));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int unsigned base;
    rst = 1'b1; id_stall = 1'b0; ex_redirect = 1'b0; ex_target = 32'h0;
    csr_xcpt = 1'b0; csr_xcpt_pc = 32'h0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    @(negedge clk);
    do_reset();

    // zero-wait memory streams 0x200, 0x204, 0x208 back to back
    step_idle();
    check_eq("t1_addr0", W'({obs_req, obs_addr}), W'({1'b1, 32'h200}));
    check_eq("t1_valid0", W'(obs_valid), W'(0));
    step_idle();
    check_eq("t1_addr1", W'({obs_req, obs_addr}), W'({1'b1, 32'h204}));
    step_idle();
    check_eq("t1_addr2", W'({obs_req, obs_addr}), W'({1'b1, 32'h208}));
    check_eq("t1_valid2", W'({obs_valid, obs_pc}), W'({1'b1, 32'h200}));

    // decode stall with 0x204 at the head
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      check_eq("t2_hold_pc", W'({obs_valid, obs_pc}), W'({1'b1, 32'h204}));
    end
    check_eq("t2_req_drop", W'(obs_req), W'(0));

    // redirect while 0x20C is outstanding with a slow response
    lat_min = 4; lat_max = 4;
    run_until_grant(32'h20C, 1'b0, 20);
    lat_min = 1; lat_max = 1;
    step(1'b0, 1'b1, 32'h400, 1'b0, 32'h0, 1'b0);
    step_idle();
    check_eq("t3_drop_req", W'(obs_req), W'(0));
    run_until_valid("t3_target", 32'h400, 20);

    // CSR trap beats a simultaneous EX redirect
    step(1'b0, 1'b1, 32'h400, 1'b1, 32'h100, 1'b0);
    step_idle();
    check_eq("t4_addr", W'({obs_req, obs_addr}), W'({1'b1, 32'h100}));
    run_until_valid("t4_target", 32'h100, 20);

    // misaligned redirect target
    step(1'b0, 1'b1, 32'h402, 1'b0, 32'h0, 1'b0);
    step_idle();
    check_eq("t5_gap", W'({obs_valid, obs_req}), W'(0));
    step_idle();
    check_eq("t5_entry", W'({obs_valid, obs_xcpt, obs_pc}), W'({2'b11, 32'h402}));
    check_eq("t5_src", W'(obs_src), W'(ECODE_INST_ADDR_MISALIGNED));
    check_eq("t5_inst", W'(obs_inst), W'(32'h0000_0013));
    check_eq("t5_req", W'(obs_req), W'(0));
    for (int i = 0; i < 3; i++) begin
      step_idle();
      check_eq("t5_halted", W'({obs_valid, obs_req}), W'(0));
    end

    // PC wraps from 0xFFFF_FFFC to 0
    step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0, 1'b0);
    base = n_accept;
    for (int i = 0; i < 40 && n_accept < base + 3; i++) step_idle();
    check_eq("wrap_pc", W'(last_acc_pc), W'(32'h0));

    // reset while a slow fetch is outstanding; its response must be dropped
    lat_min = 3; lat_max = 3;
    run_until_grant(32'h0, 1'b1, 20);
    do_reset();
    lat_min = 1; lat_max = 1;
    run_until_valid("t6_first_pc", 32'h200, 20);

    // randomized traffic
    lat_min = 1; lat_max = 4; gnt_pct = 70;
    base = n_accept;
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      logic [31:0] t1, t2;
      r  = $urandom_range(999);
      t1 = {22'h0, 8'($urandom_range(255)), 2'b00};
      t2 = {22'h1, 8'($urandom_range(255)), 2'b00};
      if ($urandom_range(4) == 0) t1[1:0] = 2'($urandom_range(3, 1));
      if ($urandom_range(4) == 0) t2[1:0] = 2'($urandom_range(3, 1));
      if (r < 2) do_reset();
      else step($urandom_range(99) < 30, r < 40, t1, r < 20 || r >= 990, t2, 1'b0);
    end
    check_eq("progress", W'(n_accept > base + 200), W'(1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
